// File: rtl/game_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_controller_if
//  Description : Signal bundle between the game-flow sequencer and the rest
//                of the invaders game (scoring, sprites, invader logic).
//                master : the sequencer (consumes game inputs, drives flow)
//                slave  : the surrounding game logic / environment
//  Ports       : tick, start_btn, player_collision, invaders_bottom,
//                invaders_remaining[5:0], lives[1:0], score[6:0]  -> sequencer
//                state[2:0], game_run, game_clear, respawn, wave_load,
//                level[2:0], high_score[6:0]                      <- sequencer
//  Revision    : 1.0  initial release
// ============================================================================
interface game_controller_if;
    logic       tick;
    logic       start_btn;
    logic       player_collision;
    logic       invaders_bottom;
    logic [5:0] invaders_remaining;
    logic [1:0] lives;
    logic [6:0] score;
    logic [2:0] state;
    logic       game_run;
    logic       game_clear;
    logic       respawn;
    logic       wave_load;
    logic [2:0] level;
    logic [6:0] high_score;

    modport master (
        input  tick, start_btn, player_collision, invaders_bottom,
               invaders_remaining, lives, score,
        output state, game_run, game_clear, respawn, wave_load,
               level, high_score
    );

    modport slave (
        output tick, start_btn, player_collision, invaders_bottom,
               invaders_remaining, lives, score,
        input  state, game_run, game_clear, respawn, wave_load,
               level, high_score
    );
endinterface
`default_nettype wire

// File: rtl/game_controller.sv
`default_nettype none
// ============================================================================
//  Module      : game_controller
//  Description : Game-flow sequencer for the invaders game. Runs the
//                playfield, freezes it after a player hit or a cleared wave,
//                advances the wave number, ends the game and keeps the
//                session high score.
//  Ports       : clk   - system clock
//                arst  - asynchronous active-low reset
//                bus   - game_controller_if.master (game inputs / flow outputs)
//  Revision    : 1.0  initial release
// ============================================================================
module game_controller #(
    parameter int unsigned HIT_PAUSE_TICKS   = 120,
    parameter int unsigned CLEAR_PAUSE_TICKS = 90,
    parameter int unsigned OVER_HOLD_TICKS   = 180,
    parameter int unsigned MAX_LEVEL         = 7
) (
    input  logic               clk,
    input  logic               arst,
    game_controller_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_START       = 3'd1,
        S_PLAYING     = 3'd2,
        S_HIT         = 3'd3,
        S_LEVEL_CLEAR = 3'd4,
        S_GAME_OVER   = 3'd5
    } state_t;

    localparam logic [7:0] C_HIT_LAST   = 8'(HIT_PAUSE_TICKS - 1);
    localparam logic [7:0] C_CLEAR_LAST = 8'(CLEAR_PAUSE_TICKS - 1);
    localparam logic [7:0] C_OVER_HOLD  = 8'(OVER_HOLD_TICKS);
    localparam logic [2:0] C_MAX_LEVEL  = 3'(MAX_LEVEL);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       start_prev_q;
    logic [2:0] level_q, level_d;
    logic [6:0] high_q, high_d;
    logic       entry_q;
    logic       game_clear_q, game_clear_d;
    logic       respawn_q, respawn_d;
    logic       wave_load_q, wave_load_d;

    logic       start_edge;
    logic       hit_expired;
    logic       clear_expired;
    logic       hold_done;
    logic       counting;

    always_comb begin
        start_edge    = bus.start_btn & ~start_prev_q;
        hit_expired   = bus.tick && (cnt_q == C_HIT_LAST);
        clear_expired = bus.tick && (cnt_q == C_CLEAR_LAST);
        // The GAME_OVER counter parks at the hold value, so reaching it
        // means the hold has already expired on an earlier tick.
        hold_done     = (cnt_q == C_OVER_HOLD);
        counting      = (state_q == S_HIT) || (state_q == S_LEVEL_CLEAR) ||
                        (state_q == S_GAME_OVER);

        state_d      = state_q;
        level_d      = level_q;
        high_d       = high_q;
        game_clear_d = 1'b0;
        respawn_d    = 1'b0;
        wave_load_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d      = S_START;
                    game_clear_d = 1'b1;
                    wave_load_d  = 1'b1;
                    respawn_d    = 1'b1;
                end
            end
            S_START: begin
                state_d = S_PLAYING;
                level_d = 3'd0;
            end
            S_PLAYING: begin
                // Lives are not looked at here: the scoring block decrements
                // on the same edge, so the verdict is taken at the end of HIT.
                if (bus.invaders_bottom) begin
                    state_d = S_GAME_OVER;
                end else if (bus.player_collision) begin
                    state_d = S_HIT;
                end else if (bus.invaders_remaining == 6'd0) begin
                    state_d = S_LEVEL_CLEAR;
                end
            end
            S_HIT: begin
                if (hit_expired) begin
                    if (bus.lives == 2'd0) begin
                        state_d = S_GAME_OVER;
                    end else begin
                        state_d   = S_PLAYING;
                        respawn_d = 1'b1;
                    end
                end
            end
            S_LEVEL_CLEAR: begin
                if (clear_expired) begin
                    state_d     = S_PLAYING;
                    wave_load_d = 1'b1;
                    level_d     = (level_q >= C_MAX_LEVEL) ? C_MAX_LEVEL
                                                           : level_q + 3'd1;
                end
            end
            S_GAME_OVER: begin
                if (entry_q && (bus.score > high_q)) begin
                    high_d = bus.score;
                end
                if (hold_done && start_edge) begin
                    state_d      = S_START;
                    game_clear_d = 1'b1;
                    wave_load_d  = 1'b1;
                    respawn_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A state change always wins, so a tick on a transition edge is
        // never counted in the state being entered.
        if (state_d != state_q) begin
            cnt_d = 8'd0;
        end else if (bus.tick && counting &&
                     !((state_q == S_GAME_OVER) && hold_done)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            start_prev_q <= 1'b1;
            level_q      <= 3'd0;
            high_q       <= 7'd0;
            entry_q      <= 1'b0;
            game_clear_q <= 1'b0;
            respawn_q    <= 1'b0;
            wave_load_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_prev_q <= bus.start_btn;
            level_q      <= level_d;
            high_q       <= high_d;
            entry_q      <= (state_d != state_q);
            game_clear_q <= game_clear_d;
            respawn_q    <= respawn_d;
            wave_load_q  <= wave_load_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.game_run   = (state_q == S_PLAYING);
    assign bus.game_clear = game_clear_q;
    assign bus.respawn    = respawn_q;
    assign bus.wave_load  = wave_load_q;
    assign bus.level      = level_q;
    assign bus.high_score = high_q;

endmodule
`default_nettype wire

// File: tb/tb_game_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_controller
//  Description : Self-checking bench for game_controller. A behavioural
//                reference built on phase numbers and tick countdowns is
//                compared with the DUT every cycle, plus literal checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_game_controller;

    localparam int HIT_N   = 120;
    localparam int CLEAR_N = 90;
    localparam int HOLD_N  = 180;
    localparam int MAXLV   = 7;

    logic clk;
    logic arst;
    game_controller_if bus();

    game_controller #(
        .HIT_PAUSE_TICKS   (HIT_N),
        .CLEAR_PAUSE_TICKS (CLEAR_N),
        .OVER_HOLD_TICKS   (HOLD_N),
        .MAX_LEVEL         (MAXLV)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase is the spec state number, left is the number of
    // ticks still to wait in the current pause/hold.
    int m_phase, m_left, m_level, m_high;
    int m_clear, m_resp, m_wave, m_first, m_prevbtn;

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_level = 0; m_high = 0;
        m_clear = 0; m_resp = 0; m_wave = 0; m_first = 0; m_prevbtn = 1;
    endtask

    task automatic go(input int p);
        m_phase = p;
        m_first = (p == 5);
        case (p)
            1: begin m_clear = 1; m_resp = 1; m_wave = 1; end
            3: m_left = HIT_N;
            4: m_left = CLEAR_N;
            5: m_left = HOLD_N;
            default: ;
        endcase
    endtask

    task automatic model_update();
        int edge_seen, was_first;
        edge_seen = (bus.start_btn && !m_prevbtn);
        m_prevbtn = bus.start_btn;
        was_first = m_first;
        m_first = 0;
        m_clear = 0; m_resp = 0; m_wave = 0;
        case (m_phase)
            0: if (edge_seen) go(1);
            1: begin m_level = 0; go(2); end
            2: begin
                if (bus.invaders_bottom) go(5);
                else if (bus.player_collision) go(3);
                else if (bus.invaders_remaining == 0) go(4);
            end
            3: if (bus.tick) begin
                m_left--;
                if (m_left == 0) begin
                    if (bus.lives == 0) go(5);
                    else begin m_resp = 1; go(2); end
                end
            end
            4: if (bus.tick) begin
                m_left--;
                if (m_left == 0) begin
                    m_level = (m_level + 1 > MAXLV) ? MAXLV : m_level + 1;
                    m_wave = 1;
                    go(2);
                end
            end
            5: begin
                if (was_first && bus.score > m_high) m_high = bus.score;
                if (m_left == 0 && edge_seen) go(1);
                else if (bus.tick && m_left > 0) m_left--;
            end
            default: ;
        endcase
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (arst) begin
            total++;
            if (bus.state != 3'(m_phase) || bus.game_run != (m_phase == 2) ||
                bus.game_clear != 1'(m_clear) || bus.respawn != 1'(m_resp) ||
                bus.wave_load != 1'(m_wave) || bus.level != 3'(m_level) ||
                bus.high_score != 7'(m_high)) begin
                bad++;
                $display("FAIL model_cmp t=%0t got st=%0d run=%0d clr=%0d rsp=%0d wav=%0d lvl=%0d hs=%0d want st=%0d run=%0d clr=%0d rsp=%0d wav=%0d lvl=%0d hs=%0d",
                         $time, bus.state, bus.game_run, bus.game_clear, bus.respawn,
                         bus.wave_load, bus.level, bus.high_score, m_phase, (m_phase == 2),
                         m_clear, m_resp, m_wave, m_level, m_high);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // n frame ticks, each preceded by 0..2 idle cycles
    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) cyc();
            bus.tick = 1'b1;
            cyc();
            bus.tick = 1'b0;
        end
    endtask

    task automatic press_start();
        bus.start_btn = 1'b1;
        cyc();
        bus.start_btn = 1'b0;
    endtask

    initial begin
        arst = 1'b0;
        model_reset();
        bus.tick = 1'b0; bus.start_btn = 1'b0; bus.player_collision = 1'b0;
        bus.invaders_bottom = 1'b0; bus.invaders_remaining = 6'd40;
        bus.lives = 2'd3; bus.score = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", bus.state, 0);
        chk("rst_run", bus.game_run, 0);
        arst = 1'b1;
        repeat (2) cyc();

        // Start sequence
        press_start();
        chk("start_state", bus.state, 1);
        chk("start_strobes", {bus.game_clear, bus.wave_load, bus.respawn}, 7);
        cyc();
        chk("play_state", bus.state, 2);
        chk("play_run", bus.game_run, 1);
        chk("play_level", bus.level, 0);
        chk("play_strobes", {bus.game_clear, bus.wave_load, bus.respawn}, 0);

        // Hit with lives left
        bus.player_collision = 1'b1; cyc(); bus.player_collision = 1'b0;
        chk("hit_state", bus.state, 3);
        ticks(HIT_N - 1);
        chk("hit_hold", bus.state, 3);
        ticks(1);
        chk("hit_back", bus.state, 2);
        chk("hit_respawn", bus.respawn, 1);
        cyc();
        chk("hit_respawn_off", bus.respawn, 0);

        // Hit with no lives left
        bus.lives = 2'd0; bus.score = 7'd30;
        bus.player_collision = 1'b1; cyc(); bus.player_collision = 1'b0;
        ticks(HIT_N);
        chk("dead_state", bus.state, 5);
        chk("dead_respawn", bus.respawn, 0);
        cyc();
        chk("hs_30", bus.high_score, 30);

        // Start ignored during hold, accepted afterwards
        ticks(100);
        press_start(); cyc();
        chk("hold_ignore", bus.state, 5);
        ticks(HOLD_N - 100);
        press_start();
        chk("hold_accept", bus.state, 1);
        cyc();
        bus.lives = 2'd3; bus.score = 7'd0;

        // Eight cleared waves, level saturates
        for (int w = 1; w <= 8; w++) begin
            bus.invaders_remaining = 6'd0; cyc(); bus.invaders_remaining = 6'd40;
            chk("lc_state", bus.state, 4);
            ticks(CLEAR_N);
            chk("lc_wave", bus.wave_load, 1);
            chk("lc_level", bus.level, (w > MAXLV) ? MAXLV : w);
        end

        // Priority: bottom wins
        bus.score = 7'd42;
        bus.invaders_bottom = 1'b1; bus.player_collision = 1'b1; bus.invaders_remaining = 6'd0;
        cyc();
        bus.invaders_bottom = 1'b0; bus.player_collision = 1'b0; bus.invaders_remaining = 6'd40;
        chk("prio_state", bus.state, 5);
        cyc();
        chk("hs_42", bus.high_score, 42);

        // Lower score keeps the high score
        ticks(HOLD_N);
        press_start(); cyc();
        bus.score = 7'd10;
        bus.invaders_bottom = 1'b1; cyc(); bus.invaders_bottom = 1'b0;
        cyc();
        chk("hs_keep", bus.high_score, 42);

        // Asynchronous reset in the middle of a hit pause
        ticks(HOLD_N);
        press_start(); cyc(); cyc();
        bus.player_collision = 1'b1; cyc(); bus.player_collision = 1'b0;
        ticks(50);
        #2;
        arst = 1'b0;
        model_reset();
        #1;
        chk("arst_state", bus.state, 0);
        chk("arst_outs", {bus.game_run, bus.game_clear, bus.respawn, bus.wave_load}, 0);
        chk("arst_hs", bus.high_score, 0);
        bus.start_btn = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        arst = 1'b1;
        repeat (3) cyc();
        chk("held_btn_idle", bus.state, 0);
        chk("held_btn_hs", bus.high_score, 0);
        bus.start_btn = 1'b0;
        cyc();

        // Randomized play, checked every cycle by the model
        for (int i = 0; i < 6000; i++) begin
            bus.tick = ($urandom_range(0, 2) == 0);
            bus.player_collision = ($urandom_range(0, 39) == 0);
            bus.invaders_bottom = ($urandom_range(0, 299) == 0);
            bus.invaders_remaining = ($urandom_range(0, 49) == 0) ? 6'd0 : 6'($urandom_range(1, 55));
            if ($urandom_range(0, 49) == 0) bus.lives = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) bus.score = 7'($urandom_range(0, 99));
            if ($urandom_range(0, 15) == 0) bus.start_btn = ~bus.start_btn;
            if (i == 3000) begin
                #2;
                arst = 1'b0;
                model_reset();
                #10;
                arst = 1'b1;
            end
            cyc();
        end
        bus.tick = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_controller.md
Name: game_controller

Overview:
- Top-level game-flow sequencer for the invaders game.
- Decides when the playfield runs, pauses after a player hit, advances waves, and ends the game.
- Consumes the lives and score outputs of the scoring block and drives its clear, plus respawn and wave-load strobes to the sprite and invader logic.
- Holds the session high score.

Parameters:
- HIT_PAUSE_TICKS, 120, frame ticks frozen after a player hit (1..255)
- CLEAR_PAUSE_TICKS, 90, frame ticks frozen after a wave is cleared (1..255)
- OVER_HOLD_TICKS, 180, frame ticks in GAME_OVER before start is accepted again (1..255)
- MAX_LEVEL, 7, saturation value of the level counter (≤7)

Ports:
- clk  in  1  system clock
- arst  in  1  asynchronous, active-low reset (0 = reset)
- tick  in  1  one-cycle frame strobe (60 Hz)
- start_btn  in  1  debounced, synchronized start button, level-sensitive
- player_collision  in  1  one-cycle strobe: player hit (same strobe feeds scoring block)
- invaders_bottom  in  1  level: an invader reached the player row
- invaders_remaining  in  6  live invader count
- lives  in  2  from scoring block
- score  in  7  from scoring block, 0..99
- state  out  3  IDLE=0, START=1, PLAYING=2, HIT=3, LEVEL_CLEAR=4, GAME_OVER=5
- game_run  out  1  playfield motion enable
- game_clear  out  1  one-cycle strobe: clear score/lives
- respawn  out  1  one-cycle strobe: re-place player
- wave_load  out  1  one-cycle strobe: load new invader wave
- level  out  3  current wave number
- high_score  out  7  best score this session

Behaviour:
- Reset (arst=0, asynchronous): state=IDLE, game_run=0, all strobes 0, level=0, high_score=0, tick counter=0, start_prev=1. Asserting reset mid-game aborts immediately to these values.
- Start edge: start_edge = start_btn & ~start_prev; start_prev is registered every clk. A button held through reset release does not start a game.
- Tick counter (8 bit): cleared on every state change; increments on tick only in HIT, LEVEL_CLEAR and GAME_OVER. "Expired" means tick=1 and counter = N-1.
- game_run = 1 only in PLAYING (registered with state, no extra latency).
- IDLE:
  - start_edge → START.
- START (exactly 1 cycle):
  - game_clear=1, wave_load=1, respawn=1, level←0.
  - → PLAYING.
- PLAYING, evaluated in priority order:
  - invaders_bottom=1 → GAME_OVER.
  - Otherwise player_collision=1 → HIT.
  - Otherwise invaders_remaining=0 → LEVEL_CLEAR.
  - lives is not examined in PLAYING; the scoring block decrements on the same edge.
- HIT:
  - On expiry of HIT_PAUSE_TICKS: lives=0 → GAME_OVER; else respawn=1 for 1 cycle → PLAYING.
  - player_collision in HIT is ignored.
- LEVEL_CLEAR:
  - On expiry of CLEAR_PAUSE_TICKS: level ← min(level+1, MAX_LEVEL), wave_load=1 for 1 cycle → PLAYING.
- GAME_OVER:
  - On the entry cycle, if score > high_score then high_score ← score.
  - start_edge is ignored until OVER_HOLD_TICKS has expired. After that, start_edge → START.
  - high_score survives START; only arst clears it.
- Strobes are registered, high for exactly one clk, and issued on the transition edge.
- tick and start_edge in the same cycle as a transition take effect only in the new state's next cycle. The counter starts at 0.
- Inputs other than arst are synchronous to clk.

Test Plan:
- Reset, then start_btn 0→1 → state 0→1→2 on consecutive cycles. game_clear, wave_load and respawn each high exactly 1 cycle in START. level=0, game_run=1.
- PLAYING with lives=3, pulse player_collision → state=3 and game_run=0 for exactly 120 ticks, then a single respawn pulse and state=2. Repeat with lives=0 → state=5 after 120 ticks, no respawn.
- invaders_remaining→0 → state=4; after 90 ticks wave_load pulses and level=1. Clear 8 waves → level saturates at 7.
- Same cycle: invaders_bottom=1, player_collision=1, invaders_remaining=0 → state=5 (bottom wins). With score=42 and high_score=30 → high_score=42. A later game ending at score 10 leaves it at 42.
- In GAME_OVER, pulse start_btn at tick 100 → no transition. Pulse it after tick 180 → START. Hold start_btn high through reset release → stays IDLE.
- Drive arst=0 mid-HIT (counter=50) → all outputs at reset values asynchronously. After release, state=IDLE and high_score=0.
